// File: rtl/el2_dec_dbg_cmd_ctl.sv
// Debug abstract-command sequencer: accepts one GPR/CSR command, waits for
// a halted core with an empty pipe, hands the command to the IB control for
// injection, then collects write-back completion into a single response.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   dbg_cmd_req_*            command request from the debug module
//   dec_tlu_dbg_halted       core is in debug halt
//   dec_pipe_empty           nothing in flight from D to WB
//   dec_debug_accept         injected instruction taken at decode
//   dbg_wb_done/fail/rddata  injected instruction completion at write-back
//   dbg_cmd_*                registered command toward the IB control
//   dec_dbg_ifu_hold         keeps IFU instructions out of decode
//   dbg_cmd_busy             sequencer is not idle
//   dbg_resp_*               response handshake back to the debug module
module el2_dec_dbg_cmd_ctl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dbg_cmd_req_valid,
    output logic        dbg_cmd_req_ready,
    input  logic        dbg_cmd_req_write,
    input  logic [1:0]  dbg_cmd_req_type,
    input  logic [31:0] dbg_cmd_req_addr,
    input  logic [31:0] dbg_cmd_req_wdata,
    input  logic        dec_tlu_dbg_halted,
    input  logic        dec_pipe_empty,
    input  logic        dec_debug_accept,
    input  logic        dbg_wb_done,
    input  logic        dbg_wb_fail,
    input  logic [31:0] dbg_wb_rddata,
    output logic        dbg_cmd_valid,
    output logic        dbg_cmd_write,
    output logic [1:0]  dbg_cmd_type,
    output logic [31:0] dbg_cmd_addr,
    output logic [31:0] dbg_cmd_wrdata,
    output logic        dec_dbg_ifu_hold,
    output logic        dbg_cmd_busy,
    output logic        dbg_resp_valid,
    input  logic        dbg_resp_ready,
    output logic        dbg_resp_fail,
    output logic [1:0]  dbg_resp_code,
    output logic [31:0] dbg_resp_rddata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    localparam logic [1:0] RC_OK    = 2'd0;
    localparam logic [1:0] RC_UNSUP = 2'd1;
    localparam logic [1:0] RC_NHALT = 2'd2;
    localparam logic [1:0] RC_TMO   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        ISSUE,
        WAIT_DONE,
        RESP
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tmo_hit;

    logic          req_ready_q;
    logic          cmd_valid_q;
    logic          cmd_write_q;
    logic [1:0]    cmd_type_q;
    logic [31:0]   cmd_addr_q;
    logic [31:0]   cmd_wrdata_q;
    logic          hold_q;
    logic          resp_valid_q;
    logic          resp_fail_q;
    logic [1:0]    resp_code_q;
    logic [31:0]   resp_rddata_q;

    // Timeout fires on the edge where the running count would reach TIMEOUT,
    // so the response appears exactly TIMEOUT cycles after accept.
    assign cnt_d   = cnt_q + CW'(1);
    assign tmo_hit = (cnt_d == TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_type_q    <= 2'd0;
            cmd_addr_q    <= 32'd0;
            cmd_wrdata_q  <= 32'd0;
            hold_q        <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_fail_q   <= 1'b0;
            resp_code_q   <= RC_OK;
            resp_rddata_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Ready comes up one cycle after reset or response.
                    req_ready_q <= 1'b1;
                    if (req_ready_q && dbg_cmd_req_valid) begin
                        req_ready_q  <= 1'b0;
                        cnt_q        <= '0;
                        cmd_write_q  <= dbg_cmd_req_write;
                        cmd_type_q   <= dbg_cmd_req_type;
                        cmd_addr_q   <= dbg_cmd_req_addr;
                        cmd_wrdata_q <= dbg_cmd_req_wdata;
                        if (dbg_cmd_req_type[1]) begin
                            // Memory and reserved types are rejected here.
                            state_q       <= RESP;
                            resp_valid_q  <= 1'b1;
                            resp_fail_q   <= 1'b1;
                            resp_code_q   <= RC_UNSUP;
                            resp_rddata_q <= 32'd0;
                        end else begin
                            state_q <= WAIT_EMPTY;
                            hold_q  <= 1'b1;
                        end
                    end
                end
                WAIT_EMPTY: begin
                    cnt_q <= cnt_d;
                    if (!dec_tlu_dbg_halted || tmo_hit) begin
                        state_q       <= RESP;
                        hold_q        <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        resp_fail_q   <= 1'b1;
                        resp_code_q   <= dec_tlu_dbg_halted ? RC_TMO : RC_NHALT;
                        resp_rddata_q <= 32'd0;
                    end else if (dec_pipe_empty) begin
                        state_q     <= ISSUE;
                        cmd_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    cnt_q <= cnt_d;
                    if (tmo_hit) begin
                        state_q       <= RESP;
                        cmd_valid_q   <= 1'b0;
                        hold_q        <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        resp_fail_q   <= 1'b1;
                        resp_code_q   <= RC_TMO;
                        resp_rddata_q <= 32'd0;
                    end else if (dec_debug_accept) begin
                        state_q     <= WAIT_DONE;
                        cmd_valid_q <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    cnt_q <= cnt_d;
                    // Completion takes priority over a coincident timeout.
                    if (dbg_wb_done) begin
                        state_q       <= RESP;
                        hold_q        <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        resp_fail_q   <= dbg_wb_fail;
                        resp_code_q   <= dbg_wb_fail ? RC_NHALT : RC_OK;
                        resp_rddata_q <= (dbg_wb_fail || cmd_write_q) ?
                                         32'd0 : dbg_wb_rddata;
                    end else if (tmo_hit) begin
                        state_q       <= RESP;
                        hold_q        <= 1'b0;
                        resp_valid_q  <= 1'b1;
                        resp_fail_q   <= 1'b1;
                        resp_code_q   <= RC_TMO;
                        resp_rddata_q <= 32'd0;
                    end
                end
                RESP: begin
                    if (dbg_resp_ready) begin
                        state_q       <= IDLE;
                        req_ready_q   <= 1'b1;
                        resp_valid_q  <= 1'b0;
                        resp_fail_q   <= 1'b0;
                        resp_code_q   <= RC_OK;
                        resp_rddata_q <= 32'd0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dbg_cmd_req_ready = req_ready_q;
    assign dbg_cmd_valid     = cmd_valid_q;
    assign dbg_cmd_write     = cmd_write_q;
    assign dbg_cmd_type      = cmd_type_q;
    assign dbg_cmd_addr      = cmd_addr_q;
    assign dbg_cmd_wrdata    = cmd_wrdata_q;
    assign dec_dbg_ifu_hold  = hold_q;
    assign dbg_cmd_busy      = (state_q != IDLE);
    assign dbg_resp_valid    = resp_valid_q;
    assign dbg_resp_fail     = resp_fail_q;
    assign dbg_resp_code     = resp_code_q;
    assign dbg_resp_rddata   = resp_rddata_q;

endmodule

// File: tb/tb_el2_dec_dbg_cmd_ctl.sv
// Directed bench for the debug abstract-command sequencer,
// built with a 16-cycle timeout.
module tb_el2_dec_dbg_cmd_ctl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        halted;
    logic        pipe_empty;
    logic        dbg_accept;
    logic        wb_done;
    logic        wb_fail;
    logic [31:0] wb_rddata;
    logic        cmd_valid;
    logic        cmd_write;
    logic [1:0]  cmd_type;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wrdata;
    logic        ifu_hold;
    logic        busy;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_fail;
    logic [1:0]  resp_code;
    logic [31:0] resp_rddata;

    int n_tests = 0;
    int n_fail  = 0;

    el2_dec_dbg_cmd_ctl #(.TIMEOUT(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .dbg_cmd_req_valid (req_valid),
        .dbg_cmd_req_ready (req_ready),
        .dbg_cmd_req_write (req_write),
        .dbg_cmd_req_type  (req_type),
        .dbg_cmd_req_addr  (req_addr),
        .dbg_cmd_req_wdata (req_wdata),
        .dec_tlu_dbg_halted(halted),
        .dec_pipe_empty    (pipe_empty),
        .dec_debug_accept  (dbg_accept),
        .dbg_wb_done       (wb_done),
        .dbg_wb_fail       (wb_fail),
        .dbg_wb_rddata     (wb_rddata),
        .dbg_cmd_valid     (cmd_valid),
        .dbg_cmd_write     (cmd_write),
        .dbg_cmd_type      (cmd_type),
        .dbg_cmd_addr      (cmd_addr),
        .dbg_cmd_wrdata    (cmd_wrdata),
        .dec_dbg_ifu_hold  (ifu_hold),
        .dbg_cmd_busy      (busy),
        .dbg_resp_valid    (resp_valid),
        .dbg_resp_ready    (resp_ready),
        .dbg_resp_fail     (resp_fail),
        .dbg_resp_code     (resp_code),
        .dbg_resp_rddata   (resp_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, settling 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic request(input logic w, input logic [1:0] t,
                           input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_type  = t;
        req_addr  = a;
        req_wdata = d;
        step(1);
        req_valid = 1'b0;
    endtask

    task automatic take_resp(input string tag);
        resp_ready = 1'b1;
        step(1);
        resp_ready = 1'b0;
        chk({tag, "_rv_clr"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_type   = 2'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        halted     = 1'b1;
        pipe_empty = 1'b1;
        dbg_accept = 1'b0;
        wb_done    = 1'b0;
        wb_fail    = 1'b0;
        wb_rddata  = 32'd0;
        resp_ready = 1'b0;
        step(2);

        // Reset state
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hold", {31'd0, ifu_hold}, 32'd0);
        chk("rst_cvalid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        step(1);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // GPR read x5, halted and empty
        request(1'b0, 2'd0, 32'd5, 32'd0);
        chk("gpr_hold", {31'd0, ifu_hold}, 32'd1);
        chk("gpr_cv_early", {31'd0, cmd_valid}, 32'd0);
        chk("gpr_busy", {31'd0, busy}, 32'd1);
        chk("gpr_addr", cmd_addr, 32'd5);
        step(1);
        chk("gpr_cv", {31'd0, cmd_valid}, 32'd1);
        dbg_accept = 1'b1;
        step(1);
        dbg_accept = 1'b0;
        chk("gpr_cv_drop", {31'd0, cmd_valid}, 32'd0);
        chk("gpr_hold2", {31'd0, ifu_hold}, 32'd1);
        step(2);
        wb_done   = 1'b1;
        wb_rddata = 32'hDEADBEEF;
        step(1);
        wb_done = 1'b0;
        chk("gpr_rv", {31'd0, resp_valid}, 32'd1);
        chk("gpr_fail", {31'd0, resp_fail}, 32'd0);
        chk("gpr_code", {30'd0, resp_code}, 32'd0);
        chk("gpr_data", resp_rddata, 32'hDEADBEEF);
        chk("gpr_hold_off", {31'd0, ifu_hold}, 32'd0);
        take_resp("gpr");

        // CSR write 0x7C4, pipe empties after 4 cycles
        pipe_empty = 1'b0;
        request(1'b1, 2'd1, 32'h7C4, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("csr_hold", {31'd0, ifu_hold}, 32'd1);
            chk("csr_cv_wait", {31'd0, cmd_valid}, 32'd0);
            step(1);
        end
        chk("csr_hold4", {31'd0, ifu_hold}, 32'd1);
        pipe_empty = 1'b1;
        step(1);
        chk("csr_cv", {31'd0, cmd_valid}, 32'd1);
        chk("csr_hold5", {31'd0, ifu_hold}, 32'd1);
        chk("csr_write", {31'd0, cmd_write}, 32'd1);
        chk("csr_type", {30'd0, cmd_type}, 32'd1);
        chk("csr_addr", cmd_addr, 32'h7C4);
        chk("csr_wdata", cmd_wrdata, 32'h1);
        dbg_accept = 1'b1;
        step(1);
        dbg_accept = 1'b0;
        wb_done   = 1'b1;
        wb_rddata = 32'h55;
        step(1);
        wb_done = 1'b0;
        chk("csr_rv", {31'd0, resp_valid}, 32'd1);
        chk("csr_code", {30'd0, resp_code}, 32'd0);
        chk("csr_data", resp_rddata, 32'd0);
        take_resp("csr");

        // Memory type is unsupported
        request(1'b0, 2'd2, 32'h1000, 32'd0);
        chk("mem_rv", {31'd0, resp_valid}, 32'd1);
        chk("mem_fail", {31'd0, resp_fail}, 32'd1);
        chk("mem_code", {30'd0, resp_code}, 32'd1);
        chk("mem_cv", {31'd0, cmd_valid}, 32'd0);
        chk("mem_hold", {31'd0, ifu_hold}, 32'd0);
        take_resp("mem");

        // Not halted
        halted = 1'b0;
        request(1'b0, 2'd0, 32'd7, 32'd0);
        chk("nh_hold", {31'd0, ifu_hold}, 32'd1);
        chk("nh_rv_early", {31'd0, resp_valid}, 32'd0);
        step(1);
        chk("nh_rv", {31'd0, resp_valid}, 32'd1);
        chk("nh_fail", {31'd0, resp_fail}, 32'd1);
        chk("nh_code", {30'd0, resp_code}, 32'd2);
        chk("nh_cv", {31'd0, cmd_valid}, 32'd0);
        take_resp("nh");
        halted = 1'b1;

        // Timeout: command never consumed
        request(1'b0, 2'd0, 32'd9, 32'd0);
        step(15);
        chk("tmo_rv_early", {31'd0, resp_valid}, 32'd0);
        chk("tmo_cv_up", {31'd0, cmd_valid}, 32'd1);
        step(1);
        chk("tmo_rv", {31'd0, resp_valid}, 32'd1);
        chk("tmo_fail", {31'd0, resp_fail}, 32'd1);
        chk("tmo_code", {30'd0, resp_code}, 32'd3);
        chk("tmo_cv", {31'd0, cmd_valid}, 32'd0);
        chk("tmo_hold", {31'd0, ifu_hold}, 32'd0);
        take_resp("tmo");

        // Completion on the very edge the timeout would fire
        request(1'b0, 2'd0, 32'd10, 32'd0);
        step(1);
        dbg_accept = 1'b1;
        step(1);
        dbg_accept = 1'b0;
        step(13);
        chk("race_rv_early", {31'd0, resp_valid}, 32'd0);
        wb_done   = 1'b1;
        wb_rddata = 32'h1234;
        step(1);
        wb_done = 1'b0;
        chk("race_rv", {31'd0, resp_valid}, 32'd1);
        chk("race_code", {30'd0, resp_code}, 32'd0);
        chk("race_fail", {31'd0, resp_fail}, 32'd0);
        chk("race_data", resp_rddata, 32'h1234);
        take_resp("race");

        // Reset while waiting for completion
        request(1'b0, 2'd0, 32'd11, 32'd0);
        step(1);
        dbg_accept = 1'b1;
        step(1);
        dbg_accept = 1'b0;
        chk("ar_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_hold", {31'd0, ifu_hold}, 32'd0);
        chk("ar_addr", cmd_addr, 32'd0);
        chk("ar_ready", {31'd0, req_ready}, 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("ar_ready2", {31'd0, req_ready}, 32'd1);
        wb_done   = 1'b1;
        wb_rddata = 32'hBAD;
        step(1);
        wb_done = 1'b0;
        chk("ar_done_ign", {31'd0, resp_valid}, 32'd0);
        chk("ar_done_busy", {31'd0, busy}, 32'd0);

        // Next command completes normally; response held with ready low
        request(1'b1, 2'd0, 32'd3, 32'hAA);
        step(1);
        dbg_accept = 1'b1;
        step(1);
        dbg_accept = 1'b0;
        wb_done = 1'b1;
        wb_fail = 1'b1;
        step(1);
        wb_done = 1'b0;
        wb_fail = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rv", {31'd0, resp_valid}, 32'd1);
            chk("hold_fields", {29'd0, resp_fail, resp_code}, 32'h6);
            chk("hold_data", resp_rddata, 32'd0);
            step(1);
        end
        chk("hold_wdata", cmd_wrdata, 32'hAA);
        take_resp("hold");
        chk("keep_addr", cmd_addr, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/el2_dec_dbg_cmd_ctl.md
# el2_dec_dbg_cmd_ctl

Debug abstract-command sequencer in the decode stage. It accepts one GPR/CSR abstract command at a time from the debug module and holds off the IFU. It waits for the core to be halted with an empty pipe, then presents the command to the IB control for instruction injection. It collects write-back completion and returns a single response with status, read data and a timeout guard.

## Interface
- TIMEOUT, 255: max cycles from accept to completion before a forced timeout; 1..65535. The counter is $clog2(TIMEOUT+1) bits.
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- dbg_cmd_req_valid  in  1  debug module command request
- dbg_cmd_req_ready  out  1  command accepted when valid & ready
- dbg_cmd_req_write  in  1  1 = write, 0 = read
- dbg_cmd_req_type  in  2  0 = GPR, 1 = CSR, 2 = memory, 3 = reserved
- dbg_cmd_req_addr  in  32  register/CSR address
- dbg_cmd_req_wdata  in  32  write data
- dec_tlu_dbg_halted  in  1  core in debug halt
- dec_pipe_empty  in  1  no instruction in flight D..WB
- dec_debug_accept  in  1  injected instruction consumed at decode this cycle
- dbg_wb_done  in  1  injected instruction completed at write-back
- dbg_wb_fail  in  1  completion with error (illegal CSR, etc.)
- dbg_wb_rddata  in  32  result data, valid with dbg_wb_done
- dbg_cmd_valid  out  1  command valid toward IB control
- dbg_cmd_write  out  1  registered write flag
- dbg_cmd_type  out  2  registered type
- dbg_cmd_addr  out  32  registered address
- dbg_cmd_wrdata  out  32  registered write data for the rs1 source
- dec_dbg_ifu_hold  out  1  block IFU instructions into decode
- dbg_cmd_busy  out  1  state != IDLE
- dbg_resp_valid  out  1  response valid
- dbg_resp_ready  in  1  debug module takes response
- dbg_resp_fail  out  1  response is an error
- dbg_resp_code  out  2  0 = ok, 1 = unsupported type, 2 = not halted, 3 = timeout
- dbg_resp_rddata  out  32  read result; 0 on writes or fail

## Operation
- States: IDLE, WAIT_EMPTY, ISSUE, WAIT_DONE, RESP. Reset state is IDLE. All outputs and registers reset to 0.
- IDLE: dbg_cmd_req_ready=1. On accept, capture write/type/addr/wdata.
  - Type 0/1 -> WAIT_EMPTY.
  - Type 2/3 -> RESP with fail=1, code=1.
- WAIT_EMPTY: dec_dbg_ifu_hold=1.
  - dec_tlu_dbg_halted=0 -> RESP, code=2.
  - Else dec_pipe_empty=1 -> ISSUE.
- ISSUE: dbg_cmd_valid=1 and dec_dbg_ifu_hold=1.
  - Hold until dec_debug_accept=1, then -> WAIT_DONE.
  - dbg_cmd_valid deasserts in the cycle after accept.
- WAIT_DONE: dec_dbg_ifu_hold=1.
  - dbg_wb_done -> RESP, fail=dbg_wb_fail, code=0 if not fail else 2.
  - On a successful read, capture dbg_wb_rddata; otherwise rddata=0.
- RESP: dbg_resp_valid=1. Response fields are stable until dbg_resp_ready; on ready -> IDLE.
- Timeout counter:
  - Cleared on accept; increments each cycle in WAIT_EMPTY/ISSUE/WAIT_DONE.
  - When the count reaches TIMEOUT in any of those states -> RESP, code=3. dbg_cmd_valid drops immediately.
- Simultaneous events:
  - dbg_wb_done and timeout in the same cycle: done wins.
  - Halt loss and pipe-empty in the same cycle in WAIT_EMPTY: not-halted fail wins.
  - dbg_wb_done outside WAIT_DONE is ignored.
  - Halt loss during ISSUE/WAIT_DONE is not checked; completion or timeout decides.
- dbg_cmd_write/type/addr/wrdata are registered outputs, constant from accept until the next accept.

## Timing
- Accept at edge N -> WAIT_EMPTY at N+1. dec_dbg_ifu_hold asserts from N+1, registered.
- Halted & empty sampled at N+1 -> dbg_cmd_valid high at N+2. Minimum accept-to-valid is 2 cycles.
- dec_debug_accept at cycle M -> WAIT_DONE at M+1.
- dbg_wb_done at cycle K -> dbg_resp_valid at K+1.
- Response/ready handshake: RESP with ready=1 -> IDLE and req_ready=1 the next cycle. Back-to-back commands therefore have a minimum 1 idle cycle between response and next accept.
- Unsupported type: accept at N -> dbg_resp_valid at N+1.
- Asynchronous reset at any point: immediate return to IDLE with all outputs 0. No response is generated for an aborted command.

## Test plan
- GPR read x5, halted and empty: req type=0, addr=5 -> dbg_cmd_valid at +2. Accept next cycle; done with rddata=0xDEADBEEF 3 cycles later -> resp fail=0, code=0, rddata=0xDEADBEEF.
- CSR write 0x7C4, wdata=0x1, pipe empty after 4 cycles -> ifu_hold high throughout, dbg_cmd_valid asserts 1 cycle after empty, resp code=0, rddata=0.
- Memory type=2 -> resp at +1, fail=1, code=1, no dbg_cmd_valid pulse, no ifu_hold.
- Not halted: halted=0 at accept -> resp code=2 one cycle after WAIT_EMPTY.
- TIMEOUT=16, never accept or done -> resp code=3 exactly 16 cycles after accept. Also: done coinciding with timeout -> code=0.
- rst pulse during WAIT_DONE -> all outputs 0; later done ignored; next command completes normally. Also: resp held 5 cycles with ready=0 -> fields stable.
